// File: rtl/tri_dispatch_if.sv
// Bundle of the triangle-setup side and fragment-generator side signals of tri_dispatch.
// master: the triangle-setup / generator-pool side that drives the inputs.
// slave : the dispatcher itself.
interface tri_dispatch_if #(
    parameter int NUM_GEN = 4
) ();
    logic                tri_valid;
    logic                tri_ready;
    logic [415:0]        tri_in;
    logic                pause;
    logic [NUM_GEN-1:0]  gen_done;
    logic [NUM_GEN-1:0]  gen_start;
    logic [415:0]        tri_out;
    logic [NUM_GEN-1:0]  gen_busy;
    logic                all_idle;
    logic [31:0]         tri_issued;
    logic [31:0]         tri_retired;
    logic                err_done;

    modport master (
        output tri_valid, tri_in, pause, gen_done,
        input  tri_ready, gen_start, tri_out, gen_busy, all_idle,
               tri_issued, tri_retired, err_done
    );

    modport slave (
        input  tri_valid, tri_in, pause, gen_done,
        output tri_ready, gen_start, tri_out, gen_busy, all_idle,
               tri_issued, tri_retired, err_done
    );
endinterface

// File: rtl/tri_dispatch.sv
// Triangle-setup scheduler: queues setup descriptors and hands each one to a
// free fragment generator, round-robin, with a one-cycle start pulse.
module tri_dispatch #(
    parameter int NUM_GEN        = 4,
    parameter int LG_TRI_FIFO_SZ = 2
) (
    input  logic            clk,
    input  logic            rst,
    tri_dispatch_if.slave   bus
);
    localparam int TRI_W = 416;
    localparam int DEPTH = 1 << LG_TRI_FIFO_SZ;
    localparam int PW    = LG_TRI_FIFO_SZ + 1;
    localparam int GW    = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    // Descriptor storage; read address is the head pointer, data lands in tri_out_q.
    logic [TRI_W-1:0]   fifo_mem [DEPTH];

    logic [PW-1:0]      head_q, tail_q;
    logic [NUM_GEN-1:0] busy_q, busy_d;
    logic [NUM_GEN-1:0] start_q, start_d;
    logic [TRI_W-1:0]   tri_out_q;
    logic [GW-1:0]      rr_ptr_q;
    logic [31:0]        issued_q, retired_q;
    logic               err_q;

    logic               fifo_empty, fifo_full, push;
    state_t             r_state;
    logic               any_free, dispatch;
    logic [GW-1:0]      sel_idx;
    logic [NUM_GEN-1:0] done_ok;
    logic               done_bad;
    logic [31:0]        retire_cnt;
    int                 scan_idx;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign fifo_empty = (head_q == tail_q);
    assign fifo_full  = (head_q[LG_TRI_FIFO_SZ-1:0] == tail_q[LG_TRI_FIFO_SZ-1:0])
                     && (head_q[LG_TRI_FIFO_SZ] != tail_q[LG_TRI_FIFO_SZ]);
    assign push       = bus.tri_valid && !fifo_full;

    // Scheduler state derived from registered FIFO and busy state plus the pause input.
    always_comb begin
        r_state = ST_IDLE;
        if (!fifo_empty) begin
            if (bus.pause || !any_free) r_state = ST_STALL;
            else                        r_state = ST_ISSUE;
        end
    end

    assign dispatch = (r_state == ST_ISSUE);

    // Round-robin search for the first idle generator starting at rr_ptr_q.
    always_comb begin
        any_free = 1'b0;
        sel_idx  = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_GEN; k++) begin
            scan_idx = (int'(rr_ptr_q) + k) % NUM_GEN;
            if (!any_free && !busy_q[scan_idx]) begin
                any_free = 1'b1;
                sel_idx  = GW'(scan_idx);
            end
        end
    end

    // Done pulses only retire generators that are actually busy; others flag an error.
    assign done_ok  = bus.gen_done & busy_q;
    assign done_bad = |(bus.gen_done & ~busy_q);

    // Number of generators retiring this cycle.
    always_comb begin
        retire_cnt = '0;
        for (int k = 0; k < NUM_GEN; k++) begin
            retire_cnt = retire_cnt + {31'd0, done_ok[k]};
        end
    end

    // Per-generator start pulse and busy flag; a freshly started generator cannot
    // also be retiring because selection only picks registered-idle generators.
    generate
        for (genvar gi = 0; gi < NUM_GEN; gi++) begin : g_gen
            assign start_d[gi] = dispatch && (sel_idx == GW'(gi));
            assign busy_d[gi]  = (busy_q[gi] && !done_ok[gi]) || start_d[gi];
        end
    endgenerate

    // Descriptor write port; left unreset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail_q[LG_TRI_FIFO_SZ-1:0]] <= bus.tri_in;
    end

    // Pointers, dispatch outputs, busy tracking and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            busy_q    <= '0;
            start_q   <= '0;
            tri_out_q <= '0;
            rr_ptr_q  <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (dispatch) begin
                tri_out_q <= fifo_mem[head_q[LG_TRI_FIFO_SZ-1:0]];
                head_q    <= head_q + PW'(1);
                rr_ptr_q  <= (sel_idx == GW'(NUM_GEN - 1)) ? '0 : sel_idx + GW'(1);
                issued_q  <= issued_q + 32'd1;
            end
            start_q   <= start_d;
            busy_q    <= busy_d;
            retired_q <= retired_q + retire_cnt;
            if (done_bad) err_q <= 1'b1;
        end
    end

    assign bus.tri_ready   = !fifo_full;
    assign bus.gen_start   = start_q;
    assign bus.tri_out     = tri_out_q;
    assign bus.gen_busy    = busy_q;
    assign bus.all_idle    = fifo_empty && (busy_q == '0);
    assign bus.tri_issued  = issued_q;
    assign bus.tri_retired = retired_q;
    assign bus.err_done    = err_q;
endmodule

// File: tb/tb_tri_dispatch.sv
// Randomised and directed bench for tri_dispatch against a queue-based reference model.
module tb_tri_dispatch;
    localparam int NG    = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tri_dispatch_if #(.NUM_GEN(NG)) bus ();

    tri_dispatch #(.NUM_GEN(NG), .LG_TRI_FIFO_SZ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (values the DUT should present after each edge).
    logic [415:0] m_q [$];
    logic [NG-1:0] m_busy;
    logic [NG-1:0] m_start;
    logic [415:0]  m_out;
    int            m_rr;
    logic [31:0]   m_issued;
    logic [31:0]   m_retired;
    logic          m_err;

    task automatic check_val(input string tag, input logic [415:0] got, input logic [415:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_val("gen_start",   bus.gen_start, m_start);
        check_val("gen_busy",    bus.gen_busy, m_busy);
        check_val("tri_out",     bus.tri_out, m_out);
        check_val("tri_ready",   bus.tri_ready, (m_q.size() < DEPTH));
        check_val("all_idle",    bus.all_idle, (m_q.size() == 0 && m_busy == '0));
        check_val("tri_issued",  bus.tri_issued, m_issued);
        check_val("tri_retired", bus.tri_retired, m_retired);
        check_val("err_done",    bus.err_done, m_err);
    endtask

    function automatic logic [415:0] rand_tri();
        logic [415:0] d;
        for (int w = 0; w < 13; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy    = '0;
        m_start   = '0;
        m_out     = '0;
        m_rr      = 0;
        m_issued  = '0;
        m_retired = '0;
        m_err     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.tri_valid = 1'b0;
        bus.pause     = 1'b0;
        bus.gen_done  = '0;
        model_reset();
        @(posedge clk);
        #1;
        $display("reset");
        compare_all();
    endtask

    // One clock: drive inputs, advance the model by the dispatch rules, compare after the edge.
    task automatic cycle(input logic v, input logic [415:0] d, input logic p, input logic [NG-1:0] dn);
        int           qs;
        logic         pushed;
        logic [NG-1:0] nb;
        int           sel;
        int           idx;
        @(negedge clk);
        rst           = 1'b0;
        bus.tri_valid = v;
        bus.tri_in    = d;
        bus.pause     = p;
        bus.gen_done  = dn;

        qs     = m_q.size();
        pushed = v && (qs < DEPTH);
        sel    = -1;
        for (int k = 0; k < NG; k++) begin
            idx = (m_rr + k) % NG;
            if (sel < 0 && !m_busy[idx]) sel = idx;
        end
        nb = m_busy;
        for (int i = 0; i < NG; i++) begin
            if (dn[i]) begin
                if (m_busy[i]) begin
                    nb[i] = 1'b0;
                    m_retired = m_retired + 32'd1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_start = '0;
        if (qs > 0 && !p && sel >= 0) begin
            m_start[sel] = 1'b1;
            nb[sel]      = 1'b1;
            m_out        = m_q.pop_front();
            m_rr         = (sel + 1) % NG;
            m_issued     = m_issued + 32'd1;
        end
        m_busy = nb;
        if (pushed) m_q.push_back(d);

        @(posedge clk);
        #1;
        if (m_start != '0) $display("issue gen_start=%b issued=%0d", m_start, m_issued);
        compare_all();
    endtask

    initial begin
        logic [415:0] d;
        logic [NG-1:0] exp2 [6];
        logic [NG-1:0] dn;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.tri_valid = 1'b0;
        bus.tri_in    = '0;
        bus.pause     = 1'b0;
        bus.gen_done  = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // 1: single descriptor latency
        do_reset();
        check_val("rst_ready", bus.tri_ready, 1'b1);
        check_val("rst_idle", bus.all_idle, 1'b1);
        d = rand_tri();
        d[415:288] = {32'd0, 32'd4, 32'd0, 32'd4};
        cycle(1'b1, d, 1'b0, '0);
        check_val("t1_no_start_t1", bus.gen_start, 4'b0000);
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t1_start", bus.gen_start, 4'b0001);
        check_val("t1_tri_out", bus.tri_out, d);
        check_val("t1_busy", bus.gen_busy, 4'b0001);
        check_val("t1_issued", bus.tri_issued, 32'd1);
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t1_pulse_one_cycle", bus.gen_start, 4'b0000);

        // 2: back-to-back pushes fill every generator, rest stalls
        do_reset();
        exp2 = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, rand_tri(), 1'b0, '0);
            check_val("t2_start_seq", bus.gen_start, exp2[k]);
        end
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t2_stall_start", bus.gen_start, 4'b0000);
        cycle(1'b1, rand_tri(), 1'b0, '0);
        cycle(1'b1, rand_tri(), 1'b0, '0);
        check_val("t2_ready_full", bus.tri_ready, 1'b0);
        cycle(1'b1, rand_tri(), 1'b0, '0);
        check_val("t2_issued_hold", bus.tri_issued, 32'd4);

        // 3: freeing generator 2 makes it the next target
        cycle(1'b0, '0, 1'b0, 4'b0100);
        check_val("t3_no_same_cycle", bus.gen_start, 4'b0000);
        check_val("t3_retired", bus.tri_retired, 32'd1);
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t3_start", bus.gen_start, 4'b0100);

        // 4: pause holds dispatch
        do_reset();
        cycle(1'b1, rand_tri(), 1'b1, '0);
        cycle(1'b1, rand_tri(), 1'b1, '0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, '0, 1'b1, '0);
            check_val("t4_paused", bus.gen_start, 4'b0000);
        end
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t4_resume0", bus.gen_start, 4'b0001);
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t4_resume1", bus.gen_start, 4'b0010);

        // 5: stray done
        do_reset();
        cycle(1'b0, '0, 1'b0, 4'b0010);
        check_val("t5_err", bus.err_done, 1'b1);
        check_val("t5_retired", bus.tri_retired, 32'd0);
        check_val("t5_busy", bus.gen_busy, 4'b0000);
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t5_sticky", bus.err_done, 1'b1);

        // 6: reset mid-operation
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, rand_tri(), 1'b1, '0);
        cycle(1'b0, '0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0);
        check_val("t6_busy_pre", bus.gen_busy, 4'b0011);
        check_val("t6_ready_pre", bus.tri_ready, 1'b1);
        do_reset();
        check_val("t6_ready", bus.tri_ready, 1'b1);
        check_val("t6_idle", bus.all_idle, 1'b1);
        check_val("t6_issued", bus.tri_issued, 32'd0);
        check_val("t6_retired", bus.tri_retired, 32'd0);
        check_val("t6_start", bus.gen_start, 4'b0000);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                dn = '0;
                for (int i = 0; i < NG; i++) begin
                    if (m_busy[i] && $urandom_range(0, 99) < 30) dn[i] = 1'b1;
                end
                if ($urandom_range(0, 99) == 0) dn[$urandom_range(0, NG-1)] = 1'b1;
                cycle(($urandom_range(0, 99) < 60), rand_tri(),
                      ($urandom_range(0, 99) < 20), dn);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
